// File: rtl/dpram_pkg.sv
// Shared definitions for the clearable dual-port RAM: clear FSM encoding and byte-lane width.
package dpram_pkg;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } dpram_state_e;

   localparam int BYTE_W = 8;

endpackage : dpram_pkg

// File: rtl/dpram_clr_seq.sv
// Clear sequencer: sweeps every address once after reset or on a clear request,
// then idles in READY. State is exported on o_state for observation.
module dpram_clr_seq
   import dpram_pkg::*;
#(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_clear,
   output logic                  o_busy,
   output logic [ADDR_WIDTH-1:0] o_clr_addr,
   output logic                  o_clr_we,
   output dpram_state_e          o_state
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

   dpram_state_e          r_state;
   dpram_state_e          w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_clr_cnt;
   logic [ADDR_WIDTH-1:0] w_clr_cnt_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_CLEAR;
         r_clr_cnt <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_clr_cnt <= w_clr_cnt_nxt;
      end
   end

   // A clear request while sweeping is ignored; the sweep never restarts early.
   always_comb begin
      w_state_nxt   = r_state;
      w_clr_cnt_nxt = r_clr_cnt;
      case (r_state)
         ST_CLEAR: begin
            w_clr_cnt_nxt = r_clr_cnt + ADDR_WIDTH'(1);
            if (r_clr_cnt == LAST_ADDR) begin
               w_state_nxt   = ST_READY;
               w_clr_cnt_nxt = '0;
            end
         end
         ST_READY: begin
            if (i_clear) begin
               w_state_nxt   = ST_CLEAR;
               w_clr_cnt_nxt = '0;
            end
         end
         default: begin
            w_state_nxt   = ST_CLEAR;
            w_clr_cnt_nxt = '0;
         end
      endcase
   end

   assign o_busy     = (r_state == ST_CLEAR);
   assign o_clr_we   = (r_state == ST_CLEAR);
   assign o_clr_addr = r_clr_cnt;
   assign o_state    = r_state;

endmodule : dpram_clr_seq

// File: rtl/dual_port_ram_clr.sv
// Byte-enabled simple dual-port RAM with a full-memory clear sweep to INIT_VALUE.
// Define DPRAM_BYPASS_EN for write-first same-address reads; default is read-first.
module dual_port_ram_clr
   import dpram_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 10,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [DATA_WIDTH-1:0]      data_i,
   input  logic [DATA_WIDTH/8-1:0]    wr_be_i,
   input  logic                       write_en_i,
   input  logic [ADDR_WIDTH-1:0]      write_addr_i,
   input  logic                       read_en_i,
   input  logic [ADDR_WIDTH-1:0]      read_addr_i,
   input  logic                       clear_i,
   output logic [DATA_WIDTH-1:0]      data_o,
   output logic                       data_valid_o,
   output logic                       busy_o
);

   localparam int MEM_SIZE  = 2 ** ADDR_WIDTH;
   localparam int NUM_BYTES = DATA_WIDTH / BYTE_W;

   logic [DATA_WIDTH-1:0] r_mem [MEM_SIZE];
   logic                  w_busy;
   logic                  w_clr_we;
   logic [ADDR_WIDTH-1:0] w_clr_addr;
   dpram_state_e          w_state;
   logic                  w_port_en;
   logic [DATA_WIDTH-1:0] w_rd_data;

   dpram_clr_seq #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_clr_seq (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_clear    (clear_i),
      .o_busy     (w_busy),
      .o_clr_addr (w_clr_addr),
      .o_clr_we   (w_clr_we),
      .o_state    (w_state)
   );

   assign w_port_en = (w_state == ST_READY);
   assign busy_o    = w_busy;

   // Storage has no reset; contents are defined only by the clear sweep and writes.
   always_ff @(posedge clk) begin
      if (w_clr_we) begin
         r_mem[w_clr_addr] <= INIT_VALUE;
      end else if (w_port_en && write_en_i) begin
         for (int b = 0; b < NUM_BYTES; b++) begin
            if (wr_be_i[b]) begin
               r_mem[write_addr_i][b*BYTE_W +: BYTE_W] <= data_i[b*BYTE_W +: BYTE_W];
            end
         end
      end
   end

`ifdef DPRAM_BYPASS_EN
   always_comb begin
      w_rd_data = r_mem[read_addr_i];
      if (write_en_i && (write_addr_i == read_addr_i)) begin
         for (int b = 0; b < NUM_BYTES; b++) begin
            if (wr_be_i[b]) begin
               w_rd_data[b*BYTE_W +: BYTE_W] = data_i[b*BYTE_W +: BYTE_W];
            end
         end
      end
   end
`else
   assign w_rd_data = r_mem[read_addr_i];
`endif

   // data_valid_o is a one-cycle strobe: high exactly on the cycle after an accepted
   // read, marking data_o as freshly loaded. There is no backpressure; data_o holds otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_o       <= '0;
         data_valid_o <= 1'b0;
      end else if (w_port_en && read_en_i) begin
         data_o       <= w_rd_data;
         data_valid_o <= 1'b1;
      end else begin
         data_valid_o <= 1'b0;
      end
   end

endmodule : dual_port_ram_clr

// File: doc/dual_port_ram_clr.md
DUAL_PORT_RAM_CLR -- requirements
Module: dual_port_ram_clr

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits; a multiple of 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, address width; depth MEM_SIZE = 2**ADDR_WIDTH.
REQ-003 SHALL have parameter INIT_VALUE, default 0, DATA_WIDTH-bit word written to every location during clear.
REQ-004 SHALL have ports (one clock; reset asynchronous, active-low):
  clk  input  1  clock, all logic on rising edge
  rst_n  input  1  asynchronous reset, active low
  data_i  input  DATA_WIDTH  write data
  wr_be_i  input  DATA_WIDTH/8  byte write enables, bit k covers data_i[8k+7:8k]
  write_en_i  input  1  write request
  write_addr_i  input  ADDR_WIDTH  write address
  read_en_i  input  1  read request
  read_addr_i  input  ADDR_WIDTH  read address
  clear_i  input  1  request full-memory clear to INIT_VALUE
  data_o  output  DATA_WIDTH  registered read data
  data_valid_o  output  1  data_o updated this cycle by a read
  busy_o  output  1  clear in progress; port requests ignored

Function
REQ-005 SHALL implement FSM with states CLEAR and READY; busy_o = 1 exactly when state is CLEAR.
REQ-006 In CLEAR, SHALL write INIT_VALUE (all bytes) to mem[clr_cnt] each cycle, clr_cnt counting 0 to MEM_SIZE-1.
REQ-007 SHALL go CLEAR -> READY on the cycle clr_cnt = MEM_SIZE-1 is written; clear takes exactly MEM_SIZE cycles.
REQ-008 In READY, clear_i = 1 SHALL go to CLEAR with clr_cnt = 0 next cycle; clear_i in CLEAR is ignored (no restart).
REQ-009 In CLEAR, write_en_i and read_en_i SHALL be ignored; data_o holds; data_valid_o = 0.
REQ-010 In READY, write_en_i = 1 SHALL update only the bytes of mem[write_addr_i] with wr_be_i bit set; wr_be_i = 0 leaves the word unchanged.
REQ-011 In READY, read_en_i = 1 SHALL load data_o with mem[read_addr_i] and set data_valid_o = 1 on the next edge; latency 1 cycle.
REQ-012 read_en_i = 0 SHALL hold data_o and clear data_valid_o.
REQ-013 If clear_i and write_en_i or read_en_i are high together in READY, the write and the read SHALL both complete in that cycle and the clear SHALL start next cycle.
REQ-014 Same-cycle read and write to one address SHALL follow REQ-020/REQ-021.
REQ-015 Writes to distinct addresses SHALL have no effect on reads of other addresses; no address wrap other than the natural ADDR_WIDTH range.

Reset
REQ-016 While rst_n = 0: state = CLEAR, clr_cnt = 0, data_o = 0, data_valid_o = 0, busy_o = 1.
REQ-017 Memory array SHALL NOT be reset asynchronously; contents become INIT_VALUE through the clear sweep after rst_n releases.
REQ-018 Reset asserted mid-clear or mid-operation SHALL abort it; the sweep restarts from address 0 after release.

Configuration
REQ-019 Macro DPRAM_BYPASS_EN SHALL select read-during-write behaviour.
REQ-020 With DPRAM_BYPASS_EN defined: on same-address read and write, data_o SHALL be the new data in enabled bytes and old data in the other bytes (write-first).
REQ-021 Without DPRAM_BYPASS_EN: on same-address read and write, data_o SHALL be the old stored word (read-first); no forwarding logic is synthesised.

Structure
REQ-022 Package dpram_pkg SHALL hold the FSM state encoding (CLEAR, READY) and the byte-lane width constant 8.
REQ-023 The clear FSM and counter SHALL be sub-module dpram_clr_seq, outputting busy, clear address, and clear write strobe; storage, byte merge and bypass stay in dual_port_ram_clr.

Verification
REQ-024 Reset then release, ADDR_WIDTH=4 -> busy_o high exactly 16 cycles; reads of all 16 addresses then return INIT_VALUE, data_valid_o high one cycle after each read_en_i.
REQ-025 Write 0xDEADBEEF to addr 3 with wr_be_i=4'b1111, then write 0x00000011 with wr_be_i=4'b0001 -> read of addr 3 returns 0xDEADBE11.
REQ-026 Same-cycle write 0xA5A5A5A5 (be=4'b0011) and read of addr 5 holding 0x12345678 -> data_o = 0x1234A5A5 with DPRAM_BYPASS_EN, 0x12345678 without.
REQ-027 clear_i pulse in READY after writes -> busy_o high MEM_SIZE cycles, write_en_i/read_en_i during it ignored, all locations read INIT_VALUE afterwards.
REQ-028 rst_n asserted at sweep address 7 -> data_o = 0, busy_o = 1 immediately; after release a full MEM_SIZE-cycle sweep from address 0.
